// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: FSM state codes, stage
// indices, per-request stall encodings and the default exception vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Stage indices into the stall vector.
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EXE = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam int NUM_STAGES = STG_WB + 1;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Hold every stage from the PC up to and including stage 'top'.
  function automatic logic [NUM_STAGES-1:0] hold_upto(input int top);
    return NUM_STAGES'((1 << (top - STG_PC + 1)) - 1);
  endfunction

  localparam logic [NUM_STAGES-1:0] STALL_NONE = '0;
  localparam logic [NUM_STAGES-1:0] STALL_IF   = hold_upto(STG_IF);
  localparam logic [NUM_STAGES-1:0] STALL_ID   = hold_upto(STG_ID);
  localparam logic [NUM_STAGES-1:0] STALL_EXE  = hold_upto(STG_EXE);
  localparam logic [NUM_STAGES-1:0] STALL_MEM  = hold_upto(STG_MEM);

  // Deepest requesting stage wins: a later stage stalling must also hold
  // everything in front of it.
  function automatic logic [NUM_STAGES-1:0] stall_encode(
    input logic req_if, input logic req_id,
    input logic req_exe, input logic req_mem);
    if (req_mem)      return STALL_MEM;
    else if (req_exe) return STALL_EXE;
    else if (req_id)  return STALL_ID;
    else if (req_if)  return STALL_IF;
    else              return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky
// timeout once the count has reached the limit.
module stall_wdog #(
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_active,
  output logic timeout
);

  localparam logic [9:0] LIMIT = 10'(WDOG_LIMIT);

  logic [9:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // Next count: clear on any free-running cycle, saturate at the limit.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | (cnt_q == LIMIT);
    if (!stall_active) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  // Counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall generation,
// one-cycle flush plus PC redirect on exceptions, and a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic                  cpu_clk_75M,
  input  logic                  cpu_rst_n,
  input  logic                  stallreq_if,
  input  logic                  stallreq_id,
  input  logic                  stallreq_exe,
  input  logic                  stallreq_mem,
  input  logic                  excp_valid,
  input  logic                  excp_eret,
  input  logic [31:0]           cp0_epc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic                  cp0_branch_flag,
  output logic [31:0]           cp0_branch_addr,
  output logic                  wdog_timeout
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;

  // Next state, redirect target capture and combinational outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    stall           = STALL_NONE;
    flush           = 1'b0;
    cp0_branch_flag = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // An exception overrides every stall request in the same cycle.
        if (excp_valid) begin
          state_d = ST_FLUSH;
          addr_d  = excp_eret ? cp0_epc : EXC_VECTOR;
        end else begin
          stall = stall_encode(stallreq_if, stallreq_id, stallreq_exe, stallreq_mem);
        end
      end
      ST_FLUSH: begin
        flush           = 1'b1;
        cp0_branch_flag = 1'b1;
        state_d         = ST_DRAIN;
      end
      // One dead cycle lets the redirected fetch settle; requests ignored.
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    // Keep the pipeline free-running while reset is held.
    if (!cpu_rst_n) begin
      stall = STALL_NONE;
    end
  end

  // State and redirect-target registers.
  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= ST_RUN;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign cp0_branch_addr = addr_q;

  stall_wdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk         (cpu_clk_75M),
    .rst_n       (cpu_rst_n),
    .stall_active((state_q == ST_RUN) && (stall != STALL_NONE)),
    .timeout     (wdog_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expected
// outputs per cycle, the monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stallreq_if, stallreq_id, stallreq_exe, stallreq_mem;
  logic        excp_valid, excp_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush, cp0_branch_flag, wdog_timeout;
  logic [31:0] cp0_branch_addr;

  pipe_ctrl dut (
    .cpu_clk_75M    (clk),
    .cpu_rst_n      (rst_n),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_exe   (stallreq_exe),
    .stallreq_mem   (stallreq_mem),
    .excp_valid     (excp_valid),
    .excp_eret      (excp_eret),
    .cp0_epc        (cp0_epc),
    .stall          (stall),
    .flush          (flush),
    .cp0_branch_flag(cp0_branch_flag),
    .cp0_branch_addr(cp0_branch_addr),
    .wdog_timeout   (wdog_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic        bflag;
    logic [31:0] addr;
    logic        wd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [3:0] R_NONE = 4'b0000;  // {mem, exe, id, if}
  localparam logic [3:0] R_IF   = 4'b0001;
  localparam logic [3:0] R_ID   = 4'b0010;
  localparam logic [3:0] R_EXE  = 4'b0100;
  localparam logic [3:0] R_MEM  = 4'b1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, ".stall"}, 32'(stall), 32'(e.stall));
      chk({e.name, ".flush"}, 32'(flush), 32'(e.flush));
      chk({e.name, ".bflag"}, 32'(cp0_branch_flag), 32'(e.bflag));
      chk({e.name, ".addr"},  cp0_branch_addr, e.addr);
      chk({e.name, ".wdog"},  32'(wdog_timeout), 32'(e.wd));
    end
  end

  task automatic cyc(input logic [3:0] r, input logic ev, input logic er, input logic [31:0] epc);
    @(posedge clk);
    #1;
    {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if} = r;
    excp_valid = ev;
    excp_eret  = er;
    cp0_epc    = epc;
  endtask

  task automatic expect_out(input string n, input logic [5:0] s, input logic f, input logic b,
                            input logic [31:0] a, input logic w);
    exp_t x;
    x.name = n; x.stall = s; x.flush = f; x.bflag = b; x.addr = a; x.wd = w;
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ad;
    rst_n = 1'b0;
    {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if} = R_MEM;
    excp_valid = 1'b1; excp_eret = 1'b0; cp0_epc = 32'h0;

    // Reset held with live requests: everything quiet.
    @(posedge clk); #1;
    expect_out("reset", 6'b000000, 0, 0, 32'h0, 0);

    // Release and request on the same cycle; honoured immediately.
    @(posedge clk); #1;
    rst_n = 1'b1;
    {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if} = R_ID;
    excp_valid = 1'b0;
    expect_out("id_only", 6'b000111, 0, 0, 32'h0, 0);
    cyc(R_IF, 0, 0, 0);                  expect_out("if_only", 6'b000011, 0, 0, 32'h0, 0);
    cyc(R_EXE, 0, 0, 0);                 expect_out("exe_only", 6'b001111, 0, 0, 32'h0, 0);
    cyc(R_MEM, 0, 0, 0);                 expect_out("mem_only", 6'b011111, 0, 0, 32'h0, 0);
    cyc(R_IF | R_EXE | R_MEM, 0, 0, 0);  expect_out("if_exe_mem", 6'b011111, 0, 0, 32'h0, 0);
    cyc(R_IF | R_ID, 0, 0, 0);           expect_out("if_id", 6'b000111, 0, 0, 32'h0, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("none", 6'b000000, 0, 0, 32'h0, 0);

    // Exception to the general vector, overriding a mem stall.
    cyc(R_MEM, 1, 0, 32'h1234_5678);     expect_out("exc_cycle", 6'b000000, 0, 0, 32'h0, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("exc_flush", 6'b000000, 1, 1, 32'hBFC0_0380, 0);
    cyc(R_MEM, 1, 1, 32'hDEAD_BEEF);     expect_out("exc_drain", 6'b000000, 0, 0, 32'hBFC0_0380, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("exc_run", 6'b000000, 0, 0, 32'hBFC0_0380, 0);

    // ERET to EPC; repeated exception in FLUSH/DRAIN must be ignored.
    cyc(R_NONE, 1, 1, 32'h8000_1234);    expect_out("eret_cycle", 6'b000000, 0, 0, 32'hBFC0_0380, 0);
    cyc(R_EXE, 1, 0, 32'h5555_0000);     expect_out("eret_flush", 6'b000000, 1, 1, 32'h8000_1234, 0);
    cyc(R_EXE, 1, 0, 32'h6666_0000);     expect_out("eret_drain", 6'b000000, 0, 0, 32'h8000_1234, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("eret_run", 6'b000000, 0, 0, 32'h8000_1234, 0);

    // ERET qualifier alone does nothing.
    cyc(R_NONE, 0, 1, 32'h1111_2222);    expect_out("eret_alone", 6'b000000, 0, 0, 32'h8000_1234, 0);
    cyc(R_ID, 0, 0, 0);                  expect_out("eret_alone_nxt", 6'b000111, 0, 0, 32'h8000_1234, 0);
    ad = 32'h8000_1234;

    // Watchdog: a one-cycle gap at 500 restarts the count.
    for (int i = 0; i < 500; i++) begin
      cyc(R_EXE, 0, 0, 0);
      if (i == 0 || i == 499) expect_out("wd_hold_a", 6'b001111, 0, 0, ad, 0);
    end
    cyc(R_NONE, 0, 0, 0);                expect_out("wd_gap", 6'b000000, 0, 0, ad, 0);
    for (int i = 0; i < 600; i++) cyc(R_EXE, 0, 0, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("wd_no_timeout", 6'b000000, 0, 0, ad, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("wd_no_timeout2", 6'b000000, 0, 0, ad, 0);

    // Watchdog: 1023 consecutive stall cycles fires a sticky timeout.
    for (int i = 0; i < 1023; i++) begin
      cyc(R_EXE, 0, 0, 0);
      if (i == 1021) expect_out("wd_hold_b", 6'b001111, 0, 0, ad, 0);
    end
    cyc(R_NONE, 0, 0, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("wd_fired", 6'b000000, 0, 0, ad, 1);
    cyc(R_NONE, 0, 0, 0);                expect_out("wd_sticky", 6'b000000, 0, 0, ad, 1);
    cyc(R_EXE, 0, 0, 0);                 expect_out("wd_stall_ok", 6'b001111, 0, 0, ad, 1);

    // Async reset in the middle of FLUSH.
    cyc(R_NONE, 1, 0, 0);                expect_out("rst_exc", 6'b000000, 0, 0, ad, 1);
    @(posedge clk); #1;
    {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if} = R_NONE;
    excp_valid = 1'b0;
    #1 rst_n = 1'b0;
    expect_out("rst_mid_flush", 6'b000000, 0, 0, 32'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if} = R_ID;
    expect_out("rst_after_run", 6'b000111, 0, 0, 32'h0, 0);
    cyc(R_NONE, 0, 0, 0);                expect_out("rst_after_idle", 6'b000000, 0, 0, 32'h0, 0);

    // Drain the scoreboard with a bounded wait.
    @(negedge clk); #1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC0_0380, meaning general exception entry address.
REQ-002 Parameter WDOG_LIMIT, default 1023, meaning consecutive-stall cycles before watchdog fires (10-bit).
REQ-003 cpu_clk_75M  in  1  single clock; all state updates on rising edge.
REQ-004 cpu_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 stallreq_if  in  1  instruction fetch not ready (imem wait).
REQ-006 stallreq_id  in  1  load-use hazard from decode.
REQ-007 stallreq_exe  in  1  multicycle op (mul/div) busy.
REQ-008 stallreq_mem  in  1  data memory wait.
REQ-009 excp_valid  in  1  exception committed in MEM stage.
REQ-010 excp_eret  in  1  qualifier with excp_valid: ERET, return to EPC.
REQ-011 cp0_epc  in  32  EPC value from CP0.
REQ-012 stall  out  6  per-stage hold: [0]PC [1]IF [2]ID [3]EXE [4]MEM [5]WB; 1 = hold.
REQ-013 flush  out  1  clear all pipeline registers this cycle.
REQ-014 cp0_branch_flag  out  1  redirect PC this cycle.
REQ-015 cp0_branch_addr  out  32  redirect target.
REQ-016 wdog_timeout  out  1  sticky: stall held WDOG_LIMIT consecutive cycles.

Function
REQ-017 FSM states SHALL be RUN, FLUSH, DRAIN; reset state RUN.
REQ-018 RUN->FLUSH when excp_valid=1; else stay RUN.
REQ-019 FLUSH->DRAIN unconditionally after one cycle; DRAIN->RUN unconditionally after one cycle.
REQ-020 In FLUSH, flush=1 and cp0_branch_flag=1 for exactly that one cycle; stall=6'b000000.
REQ-021 cp0_branch_addr SHALL be registered on the RUN->FLUSH edge: cp0_epc if excp_eret=1, else EXC_VECTOR; held constant otherwise.
REQ-022 In DRAIN, excp_valid and all stall requests SHALL be ignored; stall=0, flush=0, cp0_branch_flag=0.
REQ-023 In RUN, stall SHALL be combinational from requests, priority highest first: mem -> 6'b011111; exe -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
REQ-024 In RUN with excp_valid=1, stall SHALL be 0 that cycle (exception overrides all stall requests).
REQ-025 flush and cp0_branch_flag SHALL be 0 in RUN and DRAIN.
REQ-026 Watchdog counter (10-bit) SHALL increment each cycle stall!=0, clear to 0 on any cycle stall==0 or state!=RUN, saturate at WDOG_LIMIT.
REQ-027 When counter reaches WDOG_LIMIT, wdog_timeout SHALL set next edge and remain 1 until reset; stall behaviour unaffected.
REQ-028 Simultaneous excp_valid and excp_eret=0 SHALL select EXC_VECTOR; excp_eret without excp_valid SHALL be ignored.

Reset
REQ-029 Asserting cpu_rst_n=0 at any time, including mid-FLUSH/DRAIN, SHALL immediately force state RUN, counter 0, wdog_timeout 0, cp0_branch_addr 0.
REQ-030 During reset, stall=0, flush=0, cp0_branch_flag=0.
REQ-031 First request after deassertion SHALL be honoured on the first rising edge.

Structure
REQ-032 Stall encodings, FSM state codes, EXC_VECTOR default and stage-index constants SHALL live in the shared defines include.
REQ-033 Single module; watchdog counter MAY be a sub-module stall_wdog; no other hierarchy.

Verification
REQ-034 stallreq_id=1 only, state RUN -> stall=6'b000111 same cycle, flush=0.
REQ-035 stallreq_if=stallreq_exe=stallreq_mem=1 -> stall=6'b011111.
REQ-036 excp_valid=1, excp_eret=0, stallreq_mem=1 -> stall=0 that cycle; next cycle flush=1, cp0_branch_flag=1, cp0_branch_addr=32'hBFC00380; following cycle all 0.
REQ-037 excp_valid=1, excp_eret=1, cp0_epc=32'h8000_1234 -> next cycle cp0_branch_addr=32'h8000_1234; excp_valid repeated in DRAIN -> ignored.
REQ-038 stallreq_exe held 1023 cycles -> wdog_timeout=1 on the next edge and stays 1 after release; de-assert for one cycle at 500 -> no timeout.
REQ-039 cpu_rst_n pulsed low in FLUSH -> flush and cp0_branch_flag drop to 0 without waiting for clock; state RUN after release.
